// File: rtl/image_resize_avg_param.sv
// -----------------------------------------------------------------------------
// image_resize_avg_param
//
// Block-average image downscaler. On an accepted start it walks a SRC_W x
// SRC_H source image block by block (2^BLK_LOG2 x 2^BLK_LOG2 pixels each),
// reading every pixel of a block from a fixed-latency read port. It sums
// those pixels and emits one averaged pixel per block, in raster block order,
// on a valid/ready stream. A single-cycle done pulse follows the last block.
//
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   start_n    : active-low start; a falling edge seen in IDLE starts a frame
//   base_addr  : pixel address of source (0,0), latched on the accepted start
//   rd_en      : read request this cycle
//   rd_addr    : read address
//   rd_data    : read data, valid RD_LAT cycles after its request
//   busy       : high from the accepted start until the DONE state
//   out_valid  : averaged pixel available
//   out_ready  : consumer accepts the pixel
//   out_data   : block average
//   out_x      : block column of out_data
//   out_y      : block row of out_data
//   done       : single-cycle pulse after the last block is accepted
// -----------------------------------------------------------------------------
module image_resize_avg_param #(
  parameter int SRC_W    = 640,
  parameter int SRC_H    = 480,
  parameter int BLK_LOG2 = 3,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 23,
  parameter int RD_LAT   = 2,
  parameter int ROUND    = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start_n,
  input  logic [ADDR_W-1:0]                     base_addr,
  output logic                                  rd_en,
  output logic [ADDR_W-1:0]                     rd_addr,
  input  logic [DATA_W-1:0]                     rd_data,
  output logic                                  busy,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_W-1:0]                     out_data,
  output logic [$clog2(SRC_W>>BLK_LOG2)-1:0]    out_x,
  output logic [$clog2(SRC_H>>BLK_LOG2)-1:0]    out_y,
  output logic                                  done
);

  localparam int B     = 1 << BLK_LOG2;
  localparam int BX_N  = SRC_W >> BLK_LOG2;
  localparam int BY_N  = SRC_H >> BLK_LOG2;
  localparam int XW    = $clog2(BX_N);
  localparam int YW    = $clog2(BY_N);
  localparam int ACC_W = DATA_W + 2 * BLK_LOG2;
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  // Half of the block pixel count; added before the shift for round-half-up.
  localparam logic [ACC_W-1:0] RND = (ROUND != 0) ? ACC_W'((B * B) / 2) : {ACC_W{1'b0}};
  localparam logic [BLK_LOG2-1:0] PMAX = {BLK_LOG2{1'b1}};
  localparam logic [XW-1:0] BX_LAST = XW'(BX_N - 1);
  localparam logic [YW-1:0] BY_LAST = YW'(BY_N - 1);
  localparam logic [CNT_W-1:0] DRN_LAST = CNT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                start_n_q;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [XW-1:0]       bx_q, bx_d;
  logic [YW-1:0]       by_q, by_d;
  logic [BLK_LOG2-1:0] px_q, px_d;
  logic [BLK_LOG2-1:0] py_q, py_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [RD_LAT-1:0]   vld_q, vld_d;
  logic [CNT_W-1:0]    drn_q, drn_d;

  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                busy_q, busy_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [XW-1:0]       out_x_q, out_x_d;
  logic [YW-1:0]       out_y_q, out_y_d;
  logic                done_q, done_d;

  logic                start_acc_s;
  logic                tap_s;
  logic                hs_s;
  logic                last_col_s;
  logic                last_row_s;
  logic [ACC_W-1:0]    acc_sum_s;

  // Rounded (or truncated) block average from a completed block sum.
  function automatic logic [DATA_W-1:0] block_avg(input logic [ACC_W-1:0] sum);
    logic [ACC_W-1:0] biased;
    biased = sum + RND;
    return DATA_W'(biased >> (2 * BLK_LOG2));
  endfunction

  // Event decode shared by the next-state logic.
  always_comb begin
    start_acc_s = (state_q == S_IDLE) && start_n_q && !start_n;
    // Depth-RD_LAT tap marks the cycle when rd_data answers a request.
    tap_s       = vld_q[RD_LAT-1];
    hs_s        = out_valid_q && out_ready;
    last_col_s  = (bx_q == BX_LAST);
    last_row_s  = (by_q == BY_LAST);
    if (tap_s) begin
      acc_sum_s = acc_q + ACC_W'(rd_data);
    end else begin
      acc_sum_s = acc_q;
    end
  end

  // Read-valid shift register: a request enters at bit 0 and leaves at the tap.
  always_comb begin
    vld_d = (vld_q << 1) | RD_LAT'(rd_en_q);
  end

  // Next-state, block/pixel counters and accumulator.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    bx_d    = bx_q;
    by_d    = by_q;
    px_d    = px_q;
    py_d    = py_q;
    drn_d   = drn_q;
    acc_d   = acc_sum_s;
    case (state_q)
      S_IDLE: begin
        if (start_acc_s) begin
          state_d = S_READ;
          base_d  = base_addr;
          bx_d    = {XW{1'b0}};
          by_d    = {YW{1'b0}};
          px_d    = {BLK_LOG2{1'b0}};
          py_d    = {BLK_LOG2{1'b0}};
          drn_d   = {CNT_W{1'b0}};
          acc_d   = {ACC_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        // px and py wrap naturally at B, so they are back at 0 for the next block.
        px_d = px_q + {{(BLK_LOG2-1){1'b0}}, 1'b1};
        if (px_q == PMAX) begin
          py_d = py_q + {{(BLK_LOG2-1){1'b0}}, 1'b1};
          if (py_q == PMAX) begin
            state_d = S_DRAIN;
            drn_d   = {CNT_W{1'b0}};
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_READ;
        end
      end
      S_DRAIN: begin
        // Wait until the last request's data has been folded into acc.
        if (drn_q == DRN_LAST) begin
          state_d = S_OUT;
        end else begin
          drn_d = drn_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_OUT: begin
        if (hs_s) begin
          acc_d = {ACC_W{1'b0}};
          if (last_col_s) begin
            bx_d = {XW{1'b0}};
            if (last_row_s) begin
              by_d = {YW{1'b0}};
            end else begin
              by_d = by_q + {{(YW-1){1'b0}}, 1'b1};
            end
          end else begin
            bx_d = bx_q + {{(XW-1){1'b0}}, 1'b1};
          end
          if (last_col_s && last_row_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs, derived from the next state so they line up with it.
  always_comb begin
    rd_en_d     = (state_d == S_READ);
    busy_d      = (state_d == S_READ) || (state_d == S_DRAIN) || (state_d == S_OUT);
    out_valid_d = (state_d == S_OUT);
    done_d      = (state_d == S_DONE);
    if (state_d == S_READ) begin
      rd_addr_d = base_d
                + ADDR_W'({by_d, py_d}) * ADDR_W'(SRC_W)
                + ADDR_W'({bx_d, px_d});
    end else begin
      rd_addr_d = rd_addr_q;
    end
    // Result is captured once on entry to OUT and then held under backpressure.
    if ((state_q != S_OUT) && (state_d == S_OUT)) begin
      out_data_d = block_avg(acc_sum_s);
      out_x_d    = bx_q;
      out_y_d    = by_q;
    end else begin
      out_data_d = out_data_q;
      out_x_d    = out_x_q;
      out_y_d    = out_y_q;
    end
  end

  // Start-input sampler; resets high so a low level alone is never an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_n_q <= 1'b1;
    end else begin
      start_n_q <= start_n;
    end
  end

  // Control state, counters, accumulator and read pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= {ADDR_W{1'b0}};
      bx_q    <= {XW{1'b0}};
      by_q    <= {YW{1'b0}};
      px_q    <= {BLK_LOG2{1'b0}};
      py_q    <= {BLK_LOG2{1'b0}};
      acc_q   <= {ACC_W{1'b0}};
      vld_q   <= {RD_LAT{1'b0}};
      drn_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      px_q    <= px_d;
      py_q    <= py_d;
      acc_q   <= acc_d;
      vld_q   <= vld_d;
      drn_q   <= drn_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q     <= 1'b0;
      rd_addr_q   <= {ADDR_W{1'b0}};
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
      out_x_q     <= {XW{1'b0}};
      out_y_q     <= {YW{1'b0}};
      done_q      <= 1'b0;
    end else begin
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      done_q      <= done_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign done      = done_q;

endmodule

// File: tb/tb_image_resize_avg_param.sv
// -----------------------------------------------------------------------------
// Testbench for image_resize_avg_param, 32x16 source, 4x4 blocks, RD_LAT=2.
// Two instances share stimulus and read data: u_dut rounds, u_dut_t truncates.
// -----------------------------------------------------------------------------
module tb_image_resize_avg_param;

  localparam int SRC_W = 32;
  localparam int SRC_H = 16;
  localparam int BLK_LOG2 = 2;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 23;
  localparam int RD_LAT = 2;
  localparam int NBX = 8;
  localparam int NBLK = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              start_n;
  logic [ADDR_W-1:0] base_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_ready;

  logic              rd_en, busy, out_valid, done;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_x;
  logic [1:0]        out_y;

  logic              rd_en_t, busy_t, out_valid_t, done_t;
  logic [ADDR_W-1:0] rd_addr_t;
  logic [DATA_W-1:0] out_data_t;
  logic [2:0]        out_x_t;
  logic [1:0]        out_y_t;

  int checks = 0;
  int errors = 0;
  int img_mode = 0;
  int img_base = 0;

  image_resize_avg_param #(.SRC_W(SRC_W), .SRC_H(SRC_H), .BLK_LOG2(BLK_LOG2),
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .ROUND(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_n(start_n), .base_addr(base_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_x(out_x), .out_y(out_y), .done(done));

  image_resize_avg_param #(.SRC_W(SRC_W), .SRC_H(SRC_H), .BLK_LOG2(BLK_LOG2),
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .ROUND(0)) u_dut_t (
    .clk(clk), .rst_n(rst_n), .start_n(start_n), .base_addr(base_addr),
    .rd_en(rd_en_t), .rd_addr(rd_addr_t), .rd_data(rd_data), .busy(busy_t),
    .out_valid(out_valid_t), .out_ready(out_ready), .out_data(out_data_t),
    .out_x(out_x_t), .out_y(out_y_t), .done(done_t));

  // Image content as a function of offset from the frame origin.
  function automatic logic [7:0] pix(input int mode, input int off);
    int x;
    int y;
    x = off % SRC_W;
    y = off / SRC_W;
    case (mode)
      0: return 8'd200;
      1: return 8'(x);
      2: return 8'd255;
      default: return 8'(x + 8 * y);
    endcase
  endfunction

  // Hand-derived block averages for each image mode.
  function automatic int exp_avg(input int mode, input int bx, input int by, input bit rnd);
    case (mode)
      0: return 200;
      1: return rnd ? 4 * bx + 2 : 4 * bx + 1;
      2: return 255;
      default: return rnd ? 4 * bx + 32 * by + 14 : 4 * bx + 32 * by + 13;
    endcase
  endfunction

  // k-th read address of a frame: block raster order, pixel raster within block.
  function automatic int exp_addr(input int base, input int k);
    int b;
    int w;
    b = k / 16;
    w = k % 16;
    return base + ((b / NBX) * 4 + w / 4) * SRC_W + (b % NBX) * 4 + (w % 4);
  endfunction

  // Read port model with two cycles of latency.
  logic [ADDR_W-1:0] a1_q, a2_q;
  always @(posedge clk) begin
    a1_q <= rd_addr;
    a2_q <= a1_q;
  end
  always_comb rd_data = pix(img_mode, int'(a2_q) - img_base);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_data"}, 32'(out_data), 0);
    chk({tag, "_out_x"}, 32'(out_x), 0);
    chk({tag, "_out_y"}, 32'(out_y), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_busy_t"}, 32'(busy_t), 0);
  endtask

  // Leaves start_n high at the negedge inside the first READ cycle.
  task automatic pulse_start();
    @(negedge clk);
    start_n = 1'b0;
    @(negedge clk);
    start_n = 1'b1;
  endtask

  // Runs one frame from its first READ cycle up to the done pulse.
  task automatic run_frame(input int mode, input int base, input int hold_blk,
                           input int busy_pulse_cyc, input bit chk_timing);
    int n;
    int rd_cnt;
    int hold;
    int last;
    int cyc;
    bit got_done;
    n = 0; rd_cnt = 0; hold = 0; last = 0; cyc = 0; got_done = 1'b0;
    while (!got_done && cyc < 3000) begin
      start_n   = (cyc == busy_pulse_cyc) ? 1'b0 : 1'b1;
      out_ready = 1'b1;
      if (n == hold_blk && out_valid && hold < 5) begin
        out_ready = 1'b0;
        hold++;
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", 32'(out_data), exp_avg(mode, hold_blk % NBX, hold_blk / NBX, 1'b1));
        chk("hold_x", 32'(out_x), hold_blk % NBX);
        chk("hold_y", 32'(out_y), hold_blk / NBX);
        chk("hold_rd_en", 32'(rd_en), 0);
      end
      if (rd_en) begin
        chk("rd_addr", 32'(rd_addr), exp_addr(base, rd_cnt));
        chk("rd_addr_t", 32'(rd_addr_t), exp_addr(base, rd_cnt));
        rd_cnt++;
      end
      if (out_valid && out_ready) begin
        chk("out_x", 32'(out_x), n % NBX);
        chk("out_y", 32'(out_y), n / NBX);
        chk("out_data", 32'(out_data), exp_avg(mode, n % NBX, n / NBX, 1'b1));
        chk("out_valid_t", 32'(out_valid_t), 1);
        chk("out_data_t", 32'(out_data_t), exp_avg(mode, n % NBX, n / NBX, 1'b0));
        if (chk_timing) chk("out_spacing", 32'(cyc - last), (n == 0) ? 18 : 19);
        last = cyc;
        n++;
      end
      if (done) begin
        got_done = 1'b1;
        chk("done_busy", 32'(busy), 0);
        chk("done_t", 32'(done_t), 1);
        chk("done_delay", 32'(cyc - last), 1);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("frame_done_seen", 32'(got_done), 1);
    chk("frame_outputs", 32'(n), NBLK);
    chk("frame_reads", 32'(rd_cnt), NBLK * 16);
    if (hold_blk >= 0) chk("hold_cycles", 32'(hold), 5);
    @(negedge clk);
    chk("after_done_pulse", 32'(done), 0);
    chk("after_done_busy", 32'(busy), 0);
    chk("after_done_rd_en", 32'(rd_en), 0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    start_n = 1'b1;
    out_ready = 1'b1;
    base_addr = 23'h0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_rd_en", 32'(rd_en), 0);

    // Constant image, free-flowing output.
    img_mode = 0; img_base = 0; base_addr = 23'h0;
    pulse_start();
    run_frame(0, 0, -1, -1, 1'b1);

    // Column-ramp image at base 0x1000; base input changes after the start.
    img_mode = 1; img_base = 32'h1000; base_addr = 23'h1000;
    pulse_start();
    base_addr = 23'h0;
    run_frame(1, 32'h1000, -1, -1, 1'b1);

    // Full-scale pixels with backpressure on block (3,1).
    img_mode = 2; img_base = 32'h200; base_addr = 23'h200;
    pulse_start();
    run_frame(2, 32'h200, 11, -1, 1'b0);

    // Start pulse while busy must be ignored.
    img_mode = 3; img_base = 0; base_addr = 23'h0;
    pulse_start();
    run_frame(3, 0, -1, 100, 1'b1);

    // Reset in the middle of block (2,0) reads, then a clean restart.
    img_mode = 3; img_base = 32'h40; base_addr = 23'h40;
    pulse_start();
    k = 0;
    for (int c = 0; c < 2000 && k < 37; c++) begin
      if (rd_en) k++;
      @(negedge clk);
    end
    chk("pre_reset_reads", 32'(k), 37);
    chk("pre_reset_rd_en", 32'(rd_en), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk);
    chk("mid_reset_done", 32'(done), 0);
    rst_n = 1'b1;
    pulse_start();
    run_frame(3, 32'h40, -1, -1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
